// File: rtl/mac_arb_pkg.sv
// Shared types and constants for the MAC lookup arbiter.
package mac_arb_pkg;

   localparam int MAC_W = 48;

   // Forwarding codes returned by the engine; the arbiter passes them through untouched.
   localparam logic [2:0] DST_INVALID = 3'b110;
   localparam logic [2:0] DST_FLOOD   = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mac_lookup_arbiter_if.sv
// Bundle between the ingress requesters / lookup engine and the arbiter.
// The arbiter uses the slave modport; the surrounding logic uses master.
interface mac_lookup_arbiter_if #(
   parameter int NUM_PORTS = 4
);
   import mac_arb_pkg::*;

   // requester side
   logic [NUM_PORTS-1:0]       req;
   logic [NUM_PORTS*MAC_W-1:0] req_src_mac;
   logic [NUM_PORTS*MAC_W-1:0] req_dst_mac;
   logic [NUM_PORTS-1:0]       ack;
   logic [2:0]                 rsp_dst_port;
   logic                       rsp_timeout;

   // lookup engine side
   logic                       ml_en;
   logic [MAC_W-1:0]           ml_src_mac;
   logic [MAC_W-1:0]           ml_dst_mac;
   logic [2:0]                 ml_src_port;
   logic                       ml_done;
   logic [2:0]                 ml_dst_port;
   logic                       ml_busy;

   modport slave (
      input  req, req_src_mac, req_dst_mac, ml_done, ml_dst_port, ml_busy,
      output ack, rsp_dst_port, rsp_timeout, ml_en, ml_src_mac, ml_dst_mac, ml_src_port
   );

   modport master (
      output req, req_src_mac, req_dst_mac, ml_done, ml_dst_port, ml_busy,
      input  ack, rsp_dst_port, rsp_timeout, ml_en, ml_src_mac, ml_dst_mac, ml_src_port
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after the
// pointer, searching upward and wrapping.
module rr_arbiter #(
   parameter int NUM_PORTS = 4
) (
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [1:0]           i_ptr,
   output logic [NUM_PORTS-1:0] o_grant,
   output logic [1:0]           o_idx,
   output logic                 o_valid
);

   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [IW-1:0] w_cand;

   // Scan candidates starting from the pointer; the first hit wins.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
      o_grant = '0;
      o_idx   = 2'd0;
      o_valid = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_cand = IW'((int'(i_ptr) + k) % NUM_PORTS);
         if (!o_valid && i_req[w_cand]) begin
            o_valid         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = 2'(w_cand);
         end
      end
   end

endmodule

// File: rtl/mac_lookup_arbiter.sv
// Shares one MAC learning/lookup engine between NUM_PORTS ingress receivers.
// Grants round-robin, launches the engine, waits for its result under a
// watchdog and returns the decision to the winner with a one-cycle ack.
module mac_lookup_arbiter
   import mac_arb_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   mac_lookup_arbiter_if.slave   bus,
   output logic [15:0]           o_timeout_count
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_e           r_state;
   arb_state_e           w_next_state;
   logic [1:0]           r_ptr;
   logic [1:0]           r_winner;
   logic [NUM_PORTS-1:0] r_grant;
   logic [NUM_PORTS-1:0] r_ack;
   logic [2:0]           r_rsp_dst_port;
   logic                 r_rsp_timeout;
   logic                 r_ml_en;
   logic [MAC_W-1:0]     r_ml_src_mac;
   logic [MAC_W-1:0]     r_ml_dst_mac;
   logic [2:0]           r_ml_src_port;
   logic [WD_W-1:0]      r_wd;
   logic [15:0]          r_timeout_count;

   logic [NUM_PORTS-1:0] w_grant;
   logic [1:0]           w_idx;
   logic                 w_valid;
   logic                 w_start;
   logic                 w_expire;

   rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   // A late engine still reports busy, which holds off the next grant.
   assign w_start  = (r_state == ST_IDLE) && w_valid && !bus.ml_busy;
   // True in the last permitted WAIT cycle.
   assign w_expire = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

   // State register.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state decode; a done coinciding with expiry is treated as done.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_start) w_next_state = ST_ISSUE;
         ST_ISSUE: w_next_state = ST_WAIT;
         ST_WAIT:  if (bus.ml_done || w_expire) w_next_state = ST_RESP;
         ST_RESP:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Registered outputs, MAC capture, watchdog, expiry counter and pointer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr           <= 2'd0;
         r_winner        <= 2'd0;
         r_grant         <= '0;
         r_ack           <= '0;
         r_rsp_dst_port  <= DST_INVALID;
         r_rsp_timeout   <= 1'b0;
         r_ml_en         <= 1'b0;
         r_ml_src_mac    <= '0;
         r_ml_dst_mac    <= '0;
         r_ml_src_port   <= 3'd0;
         r_wd            <= '0;
         r_timeout_count <= 16'd0;
      end else begin
         r_ml_en <= 1'b0;
         r_ack   <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_grant       <= w_grant;
                  r_winner      <= w_idx;
                  r_ml_src_mac  <= bus.req_src_mac[int'(w_idx)*MAC_W +: MAC_W];
                  r_ml_dst_mac  <= bus.req_dst_mac[int'(w_idx)*MAC_W +: MAC_W];
                  r_ml_src_port <= {1'b0, w_idx};
                  r_ml_en       <= 1'b1;
               end
            end
            ST_ISSUE: r_wd <= '0;
            ST_WAIT: begin
               r_wd <= r_wd + WD_W'(1);
               if (bus.ml_done) begin
                  r_rsp_dst_port <= bus.ml_dst_port;
                  r_rsp_timeout  <= 1'b0;
                  r_ack          <= r_grant;
               end else if (w_expire) begin
                  r_rsp_dst_port <= DST_INVALID;
                  r_rsp_timeout  <= 1'b1;
                  r_ack          <= r_grant;
                  if (r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
               end
            end
            ST_RESP: r_ptr <= (int'(r_winner) == NUM_PORTS - 1) ? 2'd0 : r_winner + 2'd1;
            default: ;
         endcase
      end
   end

   assign bus.ack          = r_ack;
   assign bus.rsp_dst_port = r_rsp_dst_port;
   assign bus.rsp_timeout  = r_rsp_timeout;
   assign bus.ml_en        = r_ml_en;
   assign bus.ml_src_mac   = r_ml_src_mac;
   assign bus.ml_dst_mac   = r_ml_dst_mac;
   assign bus.ml_src_port  = r_ml_src_port;
   assign o_timeout_count  = r_timeout_count;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Scoreboard bench for mac_lookup_arbiter: stimulus queues the expected engine
// launches and acks (with their cycle numbers); a negedge monitor pops and compares.
module tb_mac_lookup_arbiter;
   import mac_arb_pkg::*;

   typedef struct {
      int               cyc;
      logic [2:0]       port;
      logic [MAC_W-1:0] src;
      logic [MAC_W-1:0] dst;
   } iss_t;

   typedef struct {
      int         cyc;
      logic [3:0] ack;
      logic [2:0] dst;
      logic       to;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] tc;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   iss_t iss_q[$];
   rsp_t rsp_q[$];

   // engine model configuration
   int         eng_lat;
   int         eng_cnt;
   int         eng_tail;
   logic [2:0] eng_dst_tab [4];

   mac_lookup_arbiter_if #(.NUM_PORTS(4)) bus ();

   mac_lookup_arbiter #(.NUM_PORTS(4), .TIMEOUT_CYCLES(16)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .bus             (bus.slave),
      .o_timeout_count (tc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int p, input logic [MAC_W-1:0] s, input logic [MAC_W-1:0] d);
      bus.req_src_mac[p*MAC_W +: MAC_W] = s;
      bus.req_dst_mac[p*MAC_W +: MAC_W] = d;
   endtask

   task automatic exp_iss(input int c, input int p, input logic [MAC_W-1:0] s, input logic [MAC_W-1:0] d);
      iss_t e;
      e.cyc = c; e.port = 3'(p); e.src = s; e.dst = d;
      iss_q.push_back(e);
   endtask

   task automatic exp_rsp(input int c, input int p, input logic [2:0] d, input logic to);
      rsp_t e;
      e.cyc = c; e.ack = 4'(1 << p); e.dst = d; e.to = to;
      rsp_q.push_back(e);
   endtask

   task automatic wait_ack(input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (|bus.ack) seen = 1'b1;
         else step();
      end
      check("ack_within_budget", seen, 1'b1);
   endtask

   task automatic check_reset_vals();
      check("rst_ack", bus.ack, 4'b0000);
      check("rst_ml_en", bus.ml_en, 1'b0);
      check("rst_rsp_dst", bus.rsp_dst_port, 3'b110);
      check("rst_rsp_to", bus.rsp_timeout, 1'b0);
      check("rst_src_mac", bus.ml_src_mac, 48'h0);
      check("rst_dst_mac", bus.ml_dst_mac, 48'h0);
      check("rst_src_port", bus.ml_src_port, 3'b000);
      check("rst_tc", tc, 16'h0000);
   endtask

   // Engine model: done 'eng_lat' cycles after en, busy until the cycle after done's successor.
   always @(negedge clk) begin
      if (rst) begin
         eng_cnt = 0;
         eng_tail = 0;
         bus.ml_done = 1'b0;
         bus.ml_busy = 1'b0;
         bus.ml_dst_port = 3'b000;
      end else begin
         bus.ml_done = 1'b0;
         if (eng_tail > 0) begin
            eng_tail--;
            if (eng_tail == 0) bus.ml_busy = 1'b0;
         end
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               bus.ml_done = 1'b1;
               bus.ml_dst_port = eng_dst_tab[bus.ml_src_port[1:0]];
               eng_tail = 2;
            end
         end
         if (bus.ml_en) begin
            bus.ml_busy = 1'b1;
            eng_cnt = eng_lat;
         end
      end
   end

   // Monitor: every launch and every ack must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.ml_en) begin
            check("ml_en_expected", iss_q.size() != 0, 1'b1);
            if (iss_q.size() != 0) begin
               iss_t e;
               e = iss_q.pop_front();
               check("ml_en_cycle", cyc, e.cyc);
               check("ml_src_port", bus.ml_src_port, e.port);
               check("ml_src_mac", bus.ml_src_mac, e.src);
               check("ml_dst_mac", bus.ml_dst_mac, e.dst);
            end
         end
         if (|bus.ack) begin
            check("ack_expected", rsp_q.size() != 0, 1'b1);
            if (rsp_q.size() != 0) begin
               rsp_t e;
               e = rsp_q.pop_front();
               check("ack_cycle", cyc, e.cyc);
               check("ack_vector", bus.ack, e.ack);
               check("rsp_dst_port", bus.rsp_dst_port, e.dst);
               check("rsp_timeout", bus.rsp_timeout, e.to);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL global_time_limit: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t;
      logic [MAC_W-1:0] mac_a, mac_b;
      mac_a = 48'h0011_2233_4455;
      mac_b = 48'hAABB_CCDD_EEFF;
      eng_lat = 4;
      eng_dst_tab[0] = 3'b010;
      eng_dst_tab[1] = DST_FLOOD;
      eng_dst_tab[2] = 3'b001;
      eng_dst_tab[3] = DST_INVALID;
      rst = 1'b1;
      bus.req = 4'b0000;
      bus.req_src_mac = '0;
      bus.req_dst_mac = '0;
      step(3);
      rst = 1'b0;
      check_reset_vals();

      // single request on port 2, other lanes hold decoy MACs
      step();
      t = cyc;
      for (int p = 0; p < 4; p++) set_lane(p, 48'hDEAD_0000_0000 + 48'(p), 48'hBEEF_0000_0000 + 48'(p));
      set_lane(2, mac_a, mac_b);
      bus.req = 4'b0100;
      exp_iss(t + 1, 2, mac_a, mac_b);
      exp_rsp(t + 6, 2, 3'b001, 1'b0);
      step();
      set_lane(2, 48'h1111_1111_1111, 48'h2222_2222_2222);
      wait_ack(10);
      bus.req = 4'b0000;
      step(3);

      // all ports requesting continuously from pointer 0
      rst = 1'b1;
      step();
      rst = 1'b0;
      t = cyc;
      for (int p = 0; p < 4; p++) set_lane(p, 48'h0200_0000_0000 + 48'(p), 48'h0400_0000_0000 + 48'(p));
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_iss(t + 1 + 7 * k, k % 4, 48'h0200_0000_0000 + 48'(k % 4), 48'h0400_0000_0000 + 48'(k % 4));
         exp_rsp(t + 6 + 7 * k, k % 4, eng_dst_tab[k % 4], 1'b0);
      end
      step(34);
      bus.req = 4'b0000;
      step(3);

      // hung engine on port 3; port 1 waits for busy to clear
      t = cyc;
      eng_lat = 24;
      set_lane(3, 48'h0300_0000_00A3, 48'h0300_0000_00B3);
      bus.req = 4'b1000;
      exp_iss(t + 1, 3, 48'h0300_0000_00A3, 48'h0300_0000_00B3);
      exp_rsp(t + 18, 3, DST_INVALID, 1'b1);
      step(2);
      eng_lat = 4;
      wait_ack(25);
      bus.req = 4'b0000;
      step();
      check("tc_after_timeout", tc, 16'd1);
      set_lane(1, 48'h0500_0000_00A1, 48'h0500_0000_00B1);
      bus.req = 4'b0010;
      exp_iss(t + 28, 1, 48'h0500_0000_00A1, 48'h0500_0000_00B1);
      exp_rsp(t + 33, 1, DST_FLOOD, 1'b0);
      wait_ack(20);
      bus.req = 4'b0000;
      step(3);

      // done in the same cycle as watchdog expiry
      t = cyc;
      eng_lat = 16;
      eng_dst_tab[2] = 3'b011;
      set_lane(2, 48'h0600_0000_00A2, 48'h0600_0000_00B2);
      bus.req = 4'b0100;
      exp_iss(t + 1, 2, 48'h0600_0000_00A2, 48'h0600_0000_00B2);
      exp_rsp(t + 18, 2, 3'b011, 1'b0);
      step(2);
      eng_lat = 4;
      wait_ack(25);
      bus.req = 4'b0000;
      step();
      check("tc_after_coincide", tc, 16'd1);
      step(3);

      // reset during WAIT aborts the lookup
      t = cyc;
      set_lane(0, 48'h0700_0000_00A0, 48'h0700_0000_00B0);
      bus.req = 4'b0001;
      exp_iss(t + 1, 0, 48'h0700_0000_00A0, 48'h0700_0000_00B0);
      step(3);
      rst = 1'b1;
      bus.req = 4'b0000;
      step();
      rst = 1'b0;
      check_reset_vals();
      step(2);
      t = cyc;
      bus.req = 4'b0001;
      exp_iss(t + 1, 0, 48'h0700_0000_00A0, 48'h0700_0000_00B0);
      exp_rsp(t + 6, 0, eng_dst_tab[0], 1'b0);
      wait_ack(10);
      bus.req = 4'b0000;
      step(3);

      // expiry counter saturation
      force dut.r_timeout_count = 16'hFFFF;
      step();
      release dut.r_timeout_count;
      step();
      check("tc_preset", tc, 16'hFFFF);
      t = cyc;
      eng_lat = 40;
      set_lane(1, 48'h0800_0000_00A1, 48'h0800_0000_00B1);
      bus.req = 4'b0010;
      exp_iss(t + 1, 1, 48'h0800_0000_00A1, 48'h0800_0000_00B1);
      exp_rsp(t + 18, 1, DST_INVALID, 1'b1);
      step(2);
      eng_lat = 4;
      wait_ack(25);
      bus.req = 4'b0000;
      step();
      check("tc_saturated", tc, 16'hFFFF);
      step(30);

      check("iss_queue_drained", 32'(iss_q.size()), 32'd0);
      check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
